// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants, FSM encoding and PC alignment helper for the IF stage
package inst_fetch_pkg;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_e;
  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/inst_fetch_pc_reg.sv
// inst_fetch_pc_reg: fetch PC register with +4 advance, redirect mux and alignment check
//  clk, rstn  : clock, asynchronous active-low reset
//  redirect_i : load target_i (low bits forced to 0); wins over inc_i
//  target_i   : redirect target
//  inc_i      : advance fetch PC by one word (wraps mod 2^32)
//  fetch_pc_o : address of the next word to request
//  addr_err_o : sticky flag, a misaligned redirect target was seen
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic        inc_i,
  output logic [31:0] fetch_pc_o,
  output logic        addr_err_o
);
  logic [31:0] pc_q;
  logic        err_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= redirect_i ? align(target_i) : inc_i ? pc_q + 32'd4 : pc_q;
      err_q <= err_q | (redirect_i && target_i[1:0] != 2'b00);
    end
  end
  assign fetch_pc_o = pc_q;
  assign addr_err_o = err_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: IF stage - owns the PC, issues one imem read at a time, feeds decode
//  clk, rstn            : clock, asynchronous active-low reset
//  stall                : hold outputs, park any returning word
//  redirect_valid/_pc   : branch/jump redirect from decode
//  imem_req/_addr       : read request, held with stable address until imem_ack
//  imem_ack/_rdata      : one-cycle read response
//  instruction/pc       : word to decode and its address (NOP when inst_valid=0)
//  pc_plus_4            : pc + 4
//  inst_valid           : instruction/pc hold a real fetched word
//  addr_err             : sticky misaligned-redirect flag
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        inst_valid,
  output logic        addr_err
);
  state_e      state_q, state_d;
  logic        discard_q, discard_d, valid_q, valid_d;
  logic [31:0] addr_q, addr_d, instr_q, instr_d, pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d;
  logic [31:0] fetch_pc;
  logic        ack, take, load_buf;
  // an ack outside S_WAIT has no request behind it and is ignored
  assign ack      = imem_ack && state_q == S_WAIT;
  assign take     = ack && !discard_q && !redirect_valid;
  assign load_buf = state_q == S_HOLD && !stall && !redirect_valid;
  inst_fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rstn       (rstn),
    .redirect_i (redirect_valid),
    .target_i   (redirect_pc),
    .inc_i      (take),
    .fetch_pc_o (fetch_pc),
    .addr_err_o (addr_err)
  );
  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    case (state_q)
      // a redirect here would change fetch_pc this edge, so wait one cycle to issue
      S_FETCH: if (!redirect_valid) begin
        state_d = S_WAIT;
        addr_d  = fetch_pc;
      end
      S_WAIT: if (ack) begin
        discard_d = 1'b0;
        state_d   = (take && stall) ? S_HOLD : S_FETCH;
      end else if (redirect_valid) begin
        discard_d = 1'b1;
      end
      S_HOLD: state_d = (redirect_valid || !stall) ? S_FETCH : S_HOLD;
      default: state_d = S_FETCH;
    endcase
    // a word returning under stall is parked so unconsumed output is never overwritten
    if (take && stall) begin
      buf_instr_d = imem_rdata;
      buf_pc_d    = addr_q;
    end
    if (redirect_valid) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (load_buf || (take && !stall)) begin
      valid_d = 1'b1;
      instr_d = load_buf ? buf_instr_q : imem_rdata;
      pc_d    = load_buf ? buf_pc_q : addr_q;
    end else if (valid_q && !stall) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_FETCH;
      discard_q   <= 1'b0;
      addr_q      <= RESET_PC;
      instr_q     <= NOP;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      buf_instr_q <= NOP;
      buf_pc_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end
  assign imem_req    = state_q == S_WAIT;
  assign imem_addr   = addr_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign pc_plus_4   = pc_q + 32'd4;
  assign inst_valid  = valid_q;
  ack_needs_req: assert property (@(posedge clk) disable iff (!rstn) imem_ack |-> imem_req);
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a credit-controlled instruction memory
module tb_inst_fetch;
  logic        clk = 1'b0, rstn = 1'b0, stall = 1'b0, redirect_valid = 1'b0, imem_ack = 1'b0;
  logic [31:0] redirect_pc = 32'h0, imem_rdata = 32'h0;
  logic        imem_req, inst_valid, addr_err;
  logic [31:0] imem_addr, instruction, pc, pc_plus_4;
  int          n_chk = 0, n_err = 0, grant = 0, used = 0, base = 0;
  bit          stale_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];

  inst_fetch dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .pc             (pc),
    .pc_plus_4      (pc_plus_4),
    .inst_valid     (inst_valid),
    .addr_err       (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // memory: logs each new request, acks it at the next negedge while credits remain;
  // data word is ~address. Optionally acks once during reset (stale ack).
  initial begin : mem
    bit seen = 1'b0, stale_done = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_ack) begin
        imem_ack = 1'b0;
        seen = 1'b0;
      end else if (!rstn) begin
        seen = 1'b0;
        if (stale_en && !stale_done) begin
          imem_ack   = 1'b1;
          imem_rdata = 32'h1234_5678;
          stale_done = 1'b1;
        end
      end else begin
        stale_done = 1'b0;
        if (imem_req) begin
          if (!seen) log_q.push_back(imem_addr);
          seen = 1'b1;
          if (used < grant) begin
            used++;
            imem_ack   = 1'b1;
            imem_rdata = ~imem_addr;
          end
        end
      end
    end
  end

  // monitor: every consumed word is checked against the next expected address
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (inst_valid && !stall) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL extra_word: got pc %h, expected no word", pc);
          end else begin
            e = exp_q.pop_front();
            chk("pc", pc, e);
            chk("instruction", instruction, ~e);
            chk("pc_plus_4", pc_plus_4, e + 32'd4);
          end
        end else if (!inst_valid) begin
          chk("bubble_nop", instruction, 32'h0);
        end
      end
    end
  end

  task automatic chk_reset();
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'hBFC0_0000);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_pc", pc, 32'hBFC0_0000);
    chk("rst_pc_plus_4", pc_plus_4, 32'hBFC0_0004);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk); #2;
    rstn = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    grant = used;
    repeat (3) @(posedge clk);
    #2;
    if (check) chk_reset();
    base = log_q.size();
    rstn = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic chk_log(input int k, input logic [31:0] addr);
    if (log_q.size() > base + k) chk("req_addr", log_q[base+k], addr);
    else chk("req_count", 32'(log_q.size() - base), 32'(k + 1));
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    cycles(1);
    redirect_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    // 1: reset values, then three sequential words
    do_reset(1'b1);
    grant += 3;
    exp_q.push_back(32'hBFC0_0000);
    exp_q.push_back(32'hBFC0_0004);
    exp_q.push_back(32'hBFC0_0008);
    wait_empty("t1_words");
    cycles(2);
    chk_log(0, 32'hBFC0_0000);
    chk_log(1, 32'hBFC0_0004);
    chk_log(2, 32'hBFC0_0008);
    chk_log(3, 32'hBFC0_000C);
    // 2: stall while BFC00004 is valid; BFC00008 completes but is parked
    do_reset(1'b0);
    grant += 2;
    exp_q.push_back(32'hBFC0_0000);
    exp_q.push_back(32'hBFC0_0004);
    exp_q.push_back(32'hBFC0_0008);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (inst_valid && pc == 32'hBFC0_0004) break;
    end
    stall = 1'b1;
    grant += 1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_frozen_valid", {31'h0, inst_valid}, 32'h1);
      chk("t2_frozen_pc", pc, 32'hBFC0_0004);
      chk("t2_frozen_instr", instruction, 32'h403F_FFFB);
      cycles(1);
    end
    chk("t2_one_req", 32'(log_q.size() - base), 32'd3);
    chk_log(2, 32'hBFC0_0008);
    stall = 1'b0;
    wait_empty("t2_words");
    // 3: redirect while BFC00008 outstanding, its ack arrives later and is dropped
    do_reset(1'b0);
    grant += 2;
    exp_q.push_back(32'hBFC0_0000);
    exp_q.push_back(32'hBFC0_0004);
    wait_empty("t3_pre");
    cycles(3);
    exp_q.push_back(32'h0000_1000);
    redirect(32'h0000_1000);
    cycles(2);
    grant += 2;
    wait_empty("t3_target");
    chk_log(2, 32'hBFC0_0008);
    chk_log(3, 32'h0000_1000);
    // 4: misaligned redirect coincident with ack and stall
    do_reset(1'b0);
    grant += 2;
    exp_q.push_back(32'h0000_1000);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (imem_ack) break;
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1002;
    stall = 1'b1;
    cycles(1);
    redirect_valid = 1'b0;
    stall = 1'b0;
    chk("t4_addr_err", {31'h0, addr_err}, 32'h1);
    wait_empty("t4_target");
    chk_log(0, 32'hBFC0_0000);
    chk_log(1, 32'h0000_1000);
    chk("t4_addr_err_sticky", {31'h0, addr_err}, 32'h1);
    // 5: PC wrap from FFFFFFFC to 0
    do_reset(1'b0);
    cycles(3);
    redirect(32'hFFFF_FFFC);
    grant += 3;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (inst_valid) break;
    end
    chk("t5_pc", pc, 32'hFFFF_FFFC);
    chk("t5_pc_plus_4", pc_plus_4, 32'h0000_0000);
    wait_empty("t5_words");
    chk_log(1, 32'hFFFF_FFFC);
    chk_log(2, 32'h0000_0000);
    // 6: reset while a request is outstanding, stale ack during reset
    do_reset(1'b0);
    cycles(3);
    chk("t6_req_pending", {31'h0, imem_req}, 32'h1);
    stale_en = 1'b1;
    rstn = 1'b0;
    cycles(4);
    chk_reset();
    stale_en = 1'b0;
    base = log_q.size();
    rstn = 1'b1;
    cycles(2);
    chk("t6_no_word", {31'h0, inst_valid}, 32'h0);
    grant += 1;
    exp_q.push_back(32'hBFC0_0000);
    wait_empty("t6_word");
    chk_log(0, 32'hBFC0_0000);
    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
